// File: rtl/host_line_responder.sv
// host_line_responder: serves one 512-bit host line request at a time by
// walking a word-wide backing port. Reads fill a line buffer one word per
// response; writes stream the latched line out on consecutive cycles.
module host_line_responder #(
    parameter int unsigned WORDS       = 16,
    parameter int unsigned OFFSET_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            op_host,
    input  logic [31:0]           AddrOut_host,
    input  logic [32*WORDS-1:0]   DataOut_host,
    output logic [32*WORDS-1:0]   DataIn_host,
    output logic                  rd_valid_host,
    output logic                  tx_done_host,
    output logic [31:0]           mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int unsigned LINE_W = 32 * WORDS;
    localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [31:0]      BASE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_HOLDOFF  = 3'd5;

    logic [2:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [31:0]       base_q,   base_d;
    logic              is_rd_q,  is_rd_d;
    // Shared buffer: latched write line, or the read line under assembly.
    logic [LINE_W-1:0] line_q,   line_d;
    // Last completed read line; only replaced when a read finishes.
    logic [LINE_W-1:0] rdline_q, rdline_d;

    logic [31:0]       word_addr;

    assign word_addr   = base_q + {{(30 - CNT_W){1'b0}}, cnt_q, 2'b00};
    assign DataIn_host = rdline_q;

    // Next-state, counter and buffer update for the request sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        is_rd_d  = is_rd_q;
        line_d   = line_q;
        rdline_d = rdline_q;
        case (state_q)
            ST_IDLE: begin
                if (op_host == 2'b01) begin
                    base_d  = AddrOut_host & BASE_MASK;
                    cnt_d   = '0;
                    is_rd_d = 1'b1;
                    state_d = ST_RD_ISSUE;
                end else if (op_host == 2'b10) begin
                    base_d  = AddrOut_host & BASE_MASK;
                    cnt_d   = '0;
                    is_rd_d = 1'b0;
                    line_d  = DataOut_host;
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_rvalid) begin
                    line_d[{cnt_q, 5'b00000} +: 32] = mem_rdata;
                    if (cnt_q == LAST_WORD) begin
                        rdline_d = line_d;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_WR_ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state; everything idles at zero.
    always_comb begin
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        tx_done_host  = 1'b0;
        rd_valid_host = 1'b0;
        case (state_q)
            ST_RD_ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = word_addr;
            end
            ST_WR_ISSUE: begin
                mem_wr    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = line_q[{cnt_q, 5'b00000} +: 32];
            end
            ST_DONE: begin
                tx_done_host  = 1'b1;
                rd_valid_host = is_rd_q;
            end
            default: begin
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            is_rd_q  <= 1'b0;
            line_q   <= '0;
            rdline_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            is_rd_q  <= is_rd_d;
            line_q   <= line_d;
            rdline_q <= rdline_d;
        end
    end

endmodule

// File: tb/tb_host_line_responder.sv
// Bench for host_line_responder: a transaction-level model predicts every
// output per cycle from acceptance time, a backing-memory responder answers
// mem_rd with addr^key after a chosen latency, and directed plus random
// stimulus drives the host side.
module tb_host_line_responder;

    localparam int unsigned WORDS  = 16;
    localparam int unsigned LINE_W = 32 * WORDS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        op_host;
    logic [31:0]       AddrOut_host;
    logic [LINE_W-1:0] DataOut_host;
    logic [LINE_W-1:0] DataIn_host;
    logic              rd_valid_host;
    logic              tx_done_host;
    logic [31:0]       mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata  = '0;
    logic              mem_rvalid = 1'b0;

    always #5 clk = ~clk;

    host_line_responder #(
        .WORDS       (16),
        .OFFSET_BITS (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_host       (op_host),
        .AddrOut_host  (AddrOut_host),
        .DataOut_host  (DataOut_host),
        .DataIn_host   (DataIn_host),
        .rd_valid_host (rd_valid_host),
        .tx_done_host  (tx_done_host),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int          cyc      = 0;

    // Bench-side knobs for the backing memory (latched by the model per request)
    int unsigned lat = 1;
    logic [31:0] key = 32'hA5A5A5A5;

    // Transaction model state
    bit              m_busy     = 1'b0;
    int              m_acc      = 0;
    bit              m_is_rd    = 1'b0;
    logic [31:0]     m_base     = '0;
    logic [LINE_W-1:0] m_wline  = '0;
    logic [LINE_W-1:0] m_exp_line = '0;
    int unsigned     m_lat      = 1;
    logic [31:0]     m_key      = '0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        done;
        logic        rv;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        string             name;
        logic [LINE_W-1:0] act;
        logic [LINE_W-1:0] exp;
    } lit_t;

    lit_t        lit_q[$];
    logic [31:0] rd_addrs[$];
    int unsigned wr_total = 0;
    exp_t        e_cur;
    lit_t        l_cur;

    int          due_q[$];
    logic [31:0] dat_q[$];

    function automatic int done_cycle(bit rd, int unsigned l);
        return rd ? int'(WORDS * (l + 1) + 1) : int'(WORDS + 1);
    endfunction

    function automatic logic [LINE_W-1:0] read_line(logic [31:0] base, logic [31:0] k);
        logic [LINE_W-1:0] l;
        for (int w = 0; w < int'(WORDS); w++) l[w*32 +: 32] = (base + 32'(w * 4)) ^ k;
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < int'(WORDS); w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    // Expected outputs for cycle c, derived from acceptance time and latency.
    function automatic exp_t model_out(int c);
        exp_t e;
        int   n;
        int   d;
        int   per;
        e = '0;
        if (m_busy) begin
            n   = c - m_acc + 1;
            d   = done_cycle(m_is_rd, m_lat);
            per = int'(m_lat) + 1;
            if (m_is_rd) begin
                if (n >= 1 && n < d && ((n - 1) % per) == 0) begin
                    e.rd   = 1'b1;
                    e.addr = m_base + 32'(((n - 1) / per) * 4);
                end
                if (n == d) begin
                    e.done = 1'b1;
                    e.rv   = 1'b1;
                end
            end else begin
                if (n >= 1 && n <= int'(WORDS)) begin
                    e.wr    = 1'b1;
                    e.addr  = m_base + 32'((n - 1) * 4);
                    e.wdata = m_wline[(n-1)*32 +: 32];
                end
                if (n == d) e.done = 1'b1;
            end
        end
        return e;
    endfunction

    // Model: tracks acceptance, completion and the host-visible read line.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_exp_line <= '0;
        end else if (m_busy) begin
            if (cyc - m_acc + 1 == done_cycle(m_is_rd, m_lat) + 1) m_busy <= 1'b0;
            if (m_is_rd && (cyc - m_acc + 2 == done_cycle(m_is_rd, m_lat)))
                m_exp_line <= read_line(m_base, m_key);
        end else if (op_host == 2'b01 || op_host == 2'b10) begin
            m_busy  <= 1'b1;
            m_acc   <= cyc + 1;
            m_is_rd <= (op_host == 2'b01);
            m_base  <= AddrOut_host & 32'hFFFFFFC0;
            m_wline <= DataOut_host;
            m_lat   <= lat;
            m_key   <= key;
        end
    end

    // Backing memory: one response per mem_rd, m_lat cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            dat_q.delete();
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            if (mem_rd === 1'b1) begin
                due_q.push_back(cyc + int'(m_lat));
                dat_q.push_back(mem_addr ^ m_key);
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                mem_rvalid <= 1'b0;
                mem_rdata  <= $urandom;
            end
        end
    end

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: per-cycle model check, address monitor, literal queue.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            e_cur = model_out(cyc);
            chk("strobes{rd,wr,done,rv}", {mem_rd, mem_wr, tx_done_host, rd_valid_host},
                {e_cur.rd, e_cur.wr, e_cur.done, e_cur.rv});
            chk("mem_addr", mem_addr, e_cur.addr);
            chk("mem_wdata", mem_wdata, e_cur.wdata);
            chk("DataIn_host", DataIn_host, m_exp_line);
            if (mem_rd === 1'b1) rd_addrs.push_back(mem_addr);
            if (mem_wr === 1'b1) wr_total++;
        end
        while (lit_q.size() > 0) begin
            l_cur = lit_q.pop_front();
            chk(l_cur.name, l_cur.act, l_cur.exp);
        end
    end

    task automatic lit(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        lit_q.push_back('{name, act, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the acceptance edge; counts cycles to tx_done.
    task automatic wait_done(input string name, input int exp_n);
        int n;
        n = 0;
        while (n < exp_n + 64) begin
            @(negedge clk);
            n++;
            if (tx_done_host === 1'b1) break;
        end
        lit(name, LINE_W'(n), LINE_W'(exp_n));
    endtask

    int          start;
    int          rs;
    int          g;
    int unsigned wr_start;
    int unsigned r;

    initial begin
        rst_n        = 1'b0;
        op_host      = 2'b01;
        AddrOut_host = 32'h00002014;
        DataOut_host = '0;
        lat          = 1;
        key          = 32'hA5A5A5A5;

        // Reset held with a read pending on the host side
        repeat (3) tick();
        lit("reset_no_reads", LINE_W'(rd_addrs.size()), '0);
        lit("reset_datain", DataIn_host, '0);

        // First read accepted on the first edge out of reset
        rst_n = 1'b1;
        start = rd_addrs.size();
        tick();
        op_host = 2'b00;
        wait_done("rd_latency_L1", 33);
        lit("rd_word0", LINE_W'(DataIn_host[31:0]), LINE_W'(32'hA5A585A5));
        lit("rd_word15", LINE_W'(DataIn_host[511:480]), LINE_W'(32'hA5A58599));
        lit("rd_count", LINE_W'(rd_addrs.size() - start), LINE_W'(16));
        lit("rd_first_addr", LINE_W'(rd_addrs[start]), LINE_W'(32'h00002000));
        lit("rd_last_addr", LINE_W'(rd_addrs[rd_addrs.size()-1]), LINE_W'(32'h0000203C));
        tick();
        tick();

        // Write line; read data must survive it
        op_host      = 2'b10;
        AddrOut_host = 32'h00001040;
        for (int i = 0; i < int'(WORDS); i++) DataOut_host[i*32 +: 32] = 32'h100 + 32'(i);
        wr_start = wr_total;
        tick();
        op_host = 2'b00;
        wait_done("wr_latency", 17);
        lit("wr_count", LINE_W'(wr_total - wr_start), LINE_W'(16));
        lit("wr_keeps_datain", LINE_W'(DataIn_host[31:0]), LINE_W'(32'hA5A585A5));
        tick();
        tick();

        // Host holds read op through holdoff, then issues a write
        lat          = 2;
        key          = $urandom;
        op_host      = 2'b01;
        AddrOut_host = 32'h00003000;
        start        = rd_addrs.size();
        tick();
        wait_done("rd_latency_L2", 49);
        tick();
        tick();
        op_host      = 2'b10;
        AddrOut_host = 32'h00004000;
        DataOut_host = rand_line();
        tick();
        op_host = 2'b00;
        wait_done("b2b_wr_latency", 17);
        lit("b2b_single_read", LINE_W'(rd_addrs.size() - start), LINE_W'(16));
        tick();
        tick();

        // Reset in the middle of a read
        lat          = 1;
        key          = $urandom;
        op_host      = 2'b01;
        AddrOut_host = 32'h00005000;
        start        = rd_addrs.size();
        tick();
        op_host = 2'b00;
        g = 0;
        while (rd_addrs.size() - start < 5 && g < 100) begin
            @(negedge clk);
            g++;
        end
        lit("mid_rst_5_issued", LINE_W'(rd_addrs.size() - start), LINE_W'(5));
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rs = rd_addrs.size();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        lit("mid_rst_no_more_reads", LINE_W'(rd_addrs.size() - rs), '0);
        lit("mid_rst_datain", DataIn_host, '0);
        op_host      = 2'b01;
        AddrOut_host = 32'h00006010;
        tick();
        op_host = 2'b00;
        wait_done("post_rst_rd_latency", 33);
        lit("post_rst_word0", LINE_W'(DataIn_host[31:0]), LINE_W'(32'h00006000 ^ key));
        tick();
        tick();

        // Wrapping line; inputs disturbed during the read
        key          = 32'h0;
        op_host      = 2'b01;
        AddrOut_host = 32'hFFFFFFC8;
        start        = rd_addrs.size();
        tick();
        op_host      = 2'b11;
        AddrOut_host = 32'h12345678;
        wait_done("wrap_rd_latency", 33);
        lit("wrap_first_addr", LINE_W'(rd_addrs[start]), LINE_W'(32'hFFFFFFC0));
        lit("wrap_last_addr", LINE_W'(rd_addrs[rd_addrs.size()-1]), LINE_W'(32'hFFFFFFFC));
        lit("wrap_word15", LINE_W'(DataIn_host[511:480]), LINE_W'(32'hFFFFFFFC));
        op_host = 2'b00;
        tick();
        tick();

        // Randomized traffic with occasional resets
        for (int t = 0; t < 3000; t++) begin
            if (!m_busy && $urandom_range(0, 3) == 0) begin
                lat = $urandom_range(1, 4);
                key = $urandom;
            end
            r = $urandom_range(0, 99);
            op_host      = (r < 35) ? 2'b01 : (r < 65) ? 2'b10 : (r < 82) ? 2'b00 : 2'b11;
            AddrOut_host = $urandom;
            DataOut_host = rand_line();
            rst_n        = ($urandom_range(0, 499) != 0);
            tick();
        end

        // Drain
        rst_n   = 1'b1;
        op_host = 2'b00;
        g = 0;
        while (m_busy && g < 500) begin
            tick();
            g++;
        end
        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
